// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg
//   EX->MEM pipeline register. Captures the ALU result and control, resolves
//   conditional branches from the ALU flags (the ALU has computed rs1-rs2),
//   lane-replicates store data, builds byte strobes and flags misaligned
//   loads/stores. Supports stall (hold everything) and flush (bubble).
//
//   Ports
//     clk, rst_n                    clock / async active-low reset
//     stall_mem, flush_mem          hold / bubble (flush wins)
//     ex_*                          execute-stage inputs
//     mem_*                         registered memory-stage outputs
//
//   No FSM: this is a pure pipeline register with per-edge priority
//   flush > stall > load. Every output is a flop.
module ex_mem_stage_reg #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_mem,
    input  logic              flush_mem,
    input  logic              ex_valid,
    input  logic [XLEN-1:0]   ex_result_alu,
    input  logic              ex_carry,
    input  logic              ex_zero,
    input  logic              ex_negative,
    input  logic              ex_overflow,
    input  logic [XLEN-1:0]   ex_rs2_data,
    input  logic [XLEN-1:0]   ex_pc_plus4,
    input  logic [6:0]        ex_opcode,
    input  logic [2:0]        ex_func3,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_mem_to_reg,
    input  logic [1:0]        ex_store_type,
    input  logic [2:0]        ex_load_type,
    output logic              mem_valid,
    output logic [XLEN-1:0]   mem_alu_out,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [3:0]        mem_wstrb,
    output logic [REG_AW-1:0] mem_rd,
    output logic              mem_reg_write,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              mem_mem_to_reg,
    output logic [2:0]        mem_load_type,
    output logic              mem_branch_taken,
    output logic              mem_misaligned
);

    localparam logic [6:0] OP_BTYPE = 7'b1100011;
    localparam logic [6:0] OP_JTYPE = 7'b1101111;
    localparam logic [6:0] OP_IJALR = 7'b1100111;

    localparam logic [1:0] STORE_SB  = 2'd0;
    localparam logic [1:0] STORE_SH  = 2'd1;
    localparam logic [1:0] STORE_SW  = 2'd2;

    localparam logic [2:0] LOAD_LH   = 3'd1;
    localparam logic [2:0] LOAD_LW   = 3'd2;
    localparam logic [2:0] LOAD_LHU  = 3'd4;
    localparam logic [2:0] LOAD_DEF  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    logic              valid_q,        valid_d;
    logic [XLEN-1:0]   alu_out_q,      alu_out_d;
    logic [XLEN-1:0]   addr_q,         addr_d;
    logic [XLEN-1:0]   wdata_q,        wdata_d;
    logic [3:0]        wstrb_q,        wstrb_d;
    logic [REG_AW-1:0] rd_q,           rd_d;
    logic              reg_write_q,    reg_write_d;
    logic              mem_read_q,     mem_read_d;
    logic              mem_write_q,    mem_write_d;
    logic              mem_to_reg_q,   mem_to_reg_d;
    logic [2:0]        load_type_q,    load_type_d;
    logic              branch_taken_q, branch_taken_d;
    logic              misaligned_q,   misaligned_d;

    logic [1:0]        a;
    logic              br_cond;
    logic [XLEN-1:0]   st_wdata;
    logic [3:0]        st_wstrb;
    logic              st_en;
    logic              st_mis;
    logic              ld_mis;
    logic              mis;

    always_comb begin
        a = ex_result_alu[1:0];

        br_cond = 1'b0;
        if (ex_opcode == OP_BTYPE) begin
            unique case (ex_func3)
                F3_BEQ:  br_cond = ex_zero;
                F3_BNE:  br_cond = !ex_zero;
                F3_BLT:  br_cond = ex_negative ^ ex_overflow;
                F3_BGE:  br_cond = !(ex_negative ^ ex_overflow);
                F3_BLTU: br_cond = !ex_carry;
                F3_BGEU: br_cond = ex_carry;
                default: br_cond = 1'b0;
            endcase
        end

        // Non-store cycles pass rs2 through unmodified; it is a don't-care then.
        st_wdata = ex_rs2_data;
        st_wstrb = 4'b0000;
        st_en    = 1'b0;
        st_mis   = 1'b0;
        if (ex_mem_write) begin
            unique case (ex_store_type)
                STORE_SB: begin
                    st_wdata = {4{ex_rs2_data[7:0]}};
                    st_wstrb = 4'b0001 << a;
                    st_en    = 1'b1;
                end
                STORE_SH: begin
                    st_wdata = {2{ex_rs2_data[15:0]}};
                    st_wstrb = a[1] ? 4'b1100 : 4'b0011;
                    st_en    = 1'b1;
                    st_mis   = a[0];
                end
                STORE_SW: begin
                    st_wstrb = 4'b1111;
                    st_en    = 1'b1;
                    st_mis   = (a != 2'b00);
                end
                default: begin
                    st_en    = 1'b0;
                end
            endcase
        end

        ld_mis = ex_mem_read &&
                 ((((ex_load_type == LOAD_LH) || (ex_load_type == LOAD_LHU)) && a[0]) ||
                  ((ex_load_type == LOAD_LW) && (a != 2'b00)));
        mis = st_mis || ld_mis;

        valid_d        = valid_q;
        alu_out_d      = alu_out_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        rd_d           = rd_q;
        reg_write_d    = reg_write_q;
        mem_read_d     = mem_read_q;
        mem_write_d    = mem_write_q;
        mem_to_reg_d   = mem_to_reg_q;
        load_type_d    = load_type_q;
        branch_taken_d = branch_taken_q;
        misaligned_d   = misaligned_q;

        if (flush_mem || (!stall_mem && !ex_valid)) begin
            // Bubble: kill every control bit, leave data fields as they were.
            valid_d        = 1'b0;
            reg_write_d    = 1'b0;
            mem_read_d     = 1'b0;
            mem_write_d    = 1'b0;
            mem_to_reg_d   = 1'b0;
            branch_taken_d = 1'b0;
            misaligned_d   = 1'b0;
            wstrb_d        = 4'b0000;
        end else if (!stall_mem) begin
            valid_d        = 1'b1;
            alu_out_d      = ((ex_opcode == OP_JTYPE) || (ex_opcode == OP_IJALR)) ?
                             ex_pc_plus4 : ex_result_alu;
            addr_d         = ex_result_alu;
            wdata_d        = st_wdata;
            rd_d           = ex_rd;
            mem_to_reg_d   = ex_mem_to_reg;
            load_type_d    = ex_load_type;
            branch_taken_d = br_cond;
            // A misaligned access keeps valid so the trap logic sees it, but
            // must not touch memory or the register file.
            misaligned_d   = mis;
            wstrb_d        = mis ? 4'b0000 : st_wstrb;
            mem_write_d    = st_en && !mis;
            mem_read_d     = ex_mem_read && !mis;
            reg_write_d    = ex_reg_write && !mis;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q        <= 1'b0;
            alu_out_q      <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= 4'b0000;
            rd_q           <= '0;
            reg_write_q    <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_to_reg_q   <= 1'b0;
            load_type_q    <= LOAD_DEF;
            branch_taken_q <= 1'b0;
            misaligned_q   <= 1'b0;
        end else begin
            valid_q        <= valid_d;
            alu_out_q      <= alu_out_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            wstrb_q        <= wstrb_d;
            rd_q           <= rd_d;
            reg_write_q    <= reg_write_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            mem_to_reg_q   <= mem_to_reg_d;
            load_type_q    <= load_type_d;
            branch_taken_q <= branch_taken_d;
            misaligned_q   <= misaligned_d;
        end
    end

    assign mem_valid        = valid_q;
    assign mem_alu_out      = alu_out_q;
    assign mem_addr         = addr_q;
    assign mem_wdata        = wdata_q;
    assign mem_wstrb        = wstrb_q;
    assign mem_rd           = rd_q;
    assign mem_reg_write    = reg_write_q;
    assign mem_mem_read     = mem_read_q;
    assign mem_mem_write    = mem_write_q;
    assign mem_mem_to_reg   = mem_to_reg_q;
    assign mem_load_type    = load_type_q;
    assign mem_branch_taken = branch_taken_q;
    assign mem_misaligned   = misaligned_q;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
module tb_ex_mem_stage_reg;

    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;

    typedef struct packed {
        logic        valid;
        logic [31:0] res;
        logic        c, z, n, v;
        logic [31:0] rs2;
        logic [31:0] pc4;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        rw, mr, mw, mtr;
        logic [1:0]  st;
        logic [2:0]  lt;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu_out;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [4:0]  rd;
        logic        rw, mr, mw, mtr;
        logic [2:0]  lt;
        logic        bt, mis;
    } out_t;

    localparam out_t RST = '{valid: 1'b0, alu_out: 32'h0, addr: 32'h0, wdata: 32'h0,
                             wstrb: 4'h0, rd: 5'h0, rw: 1'b0, mr: 1'b0, mw: 1'b0,
                             mtr: 1'b0, lt: 3'b111, bt: 1'b0, mis: 1'b0};

    logic clk = 1'b0;
    logic rst_n;
    logic stall_mem, flush_mem;
    in_t  din;

    logic [31:0] mem_alu_out, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [4:0]  mem_rd;
    logic [2:0]  mem_load_type;
    logic mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
    logic mem_branch_taken, mem_misaligned;

    int   checks = 0;
    int   errors = 0;
    out_t exp_cur;
    out_t sb[$];

    always #5 clk = ~clk;

    ex_mem_stage_reg #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall_mem(stall_mem), .flush_mem(flush_mem),
        .ex_valid(din.valid), .ex_result_alu(din.res),
        .ex_carry(din.c), .ex_zero(din.z), .ex_negative(din.n), .ex_overflow(din.v),
        .ex_rs2_data(din.rs2), .ex_pc_plus4(din.pc4), .ex_opcode(din.op),
        .ex_func3(din.f3), .ex_rd(din.rd), .ex_reg_write(din.rw),
        .ex_mem_read(din.mr), .ex_mem_write(din.mw), .ex_mem_to_reg(din.mtr),
        .ex_store_type(din.st), .ex_load_type(din.lt),
        .mem_valid(mem_valid), .mem_alu_out(mem_alu_out), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
        .mem_load_type(mem_load_type), .mem_branch_taken(mem_branch_taken),
        .mem_misaligned(mem_misaligned)
    );

    function automatic out_t sample();
        out_t s;
        s = '{valid: mem_valid, alu_out: mem_alu_out, addr: mem_addr, wdata: mem_wdata,
              wstrb: mem_wstrb, rd: mem_rd, rw: mem_reg_write, mr: mem_mem_read,
              mw: mem_mem_write, mtr: mem_mem_to_reg, lt: mem_load_type,
              bt: mem_branch_taken, mis: mem_misaligned};
        return s;
    endfunction

    // Reference model of one clock edge.
    function automatic out_t predict(out_t cur, in_t i, bit stall, bit flush);
        out_t  o;
        logic [1:0] a;
        logic  taken;
        o = cur;
        a = i.res[1:0];
        if (!flush && stall) return cur;
        if (flush || !i.valid) begin
            o.valid = 0; o.rw = 0; o.mr = 0; o.mw = 0; o.mtr = 0;
            o.bt = 0; o.mis = 0; o.wstrb = 4'h0;
            return o;
        end
        o.valid   = 1;
        o.alu_out = (i.op == OP_JAL || i.op == OP_JALR) ? i.pc4 : i.res;
        o.addr    = i.res;
        o.rd      = i.rd;
        o.lt      = i.lt;
        o.mtr     = i.mtr;
        taken = 0;
        if (i.op == OP_B) begin
            case (i.f3)
                3'b000: taken = i.z;
                3'b001: taken = ~i.z;
                3'b100: taken = (i.n != i.v);
                3'b101: taken = (i.n == i.v);
                3'b110: taken = ~i.c;
                3'b111: taken = i.c;
                default: taken = 0;
            endcase
        end
        o.bt    = taken;
        o.wdata = i.rs2;
        o.wstrb = 4'h0;
        o.mw    = 0;
        o.mis   = 0;
        if (i.mw) begin
            case (i.st)
                2'd0: begin
                    o.wdata = {i.rs2[7:0], i.rs2[7:0], i.rs2[7:0], i.rs2[7:0]};
                    case (a)
                        2'd0: o.wstrb = 4'b0001;
                        2'd1: o.wstrb = 4'b0010;
                        2'd2: o.wstrb = 4'b0100;
                        default: o.wstrb = 4'b1000;
                    endcase
                    o.mw = 1;
                end
                2'd1: begin
                    o.wdata = {i.rs2[15:0], i.rs2[15:0]};
                    o.wstrb = (a >= 2) ? 4'b1100 : 4'b0011;
                    o.mw = 1;
                    o.mis = (a == 1 || a == 3);
                end
                2'd2: begin
                    o.wstrb = 4'b1111;
                    o.mw = 1;
                    o.mis = (a != 0);
                end
                default: ;
            endcase
        end
        if (i.mr && (i.lt == 3'd1 || i.lt == 3'd4) && (a == 1 || a == 3)) o.mis = 1;
        if (i.mr && i.lt == 3'd2 && a != 0) o.mis = 1;
        o.mr = i.mr;
        o.rw = i.rw;
        if (o.mis) begin
            o.mw = 0; o.mr = 0; o.rw = 0; o.wstrb = 4'h0;
        end
        return o;
    endfunction

    function automatic in_t mk();
        in_t i;
        i = '0;
        i.valid = 1;
        i.op = OP_R;
        i.lt = 3'b111;
        i.st = 2'd3;
        i.rd = 5'd3;
        i.rw = 1;
        i.rs2 = 32'hCAFE_0001;
        i.pc4 = 32'h0000_0104;
        i.res = 32'h0000_1000;
        return i;
    endfunction

    function automatic in_t rand_in();
        in_t i;
        logic [2:0] lts [6];
        lts = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
        i = mk();
        i.valid = ($urandom_range(0, 7) != 0);
        i.res = $urandom; i.rs2 = $urandom; i.pc4 = $urandom;
        i.c = 1'($urandom); i.z = 1'($urandom); i.n = 1'($urandom); i.v = 1'($urandom);
        i.f3 = 3'($urandom); i.rd = 5'($urandom); i.rw = 1'($urandom);
        i.st = 2'($urandom); i.lt = lts[$urandom_range(0, 5)];
        case ($urandom_range(0, 5))
            0: i.op = OP_B;
            1: i.op = OP_JAL;
            2: i.op = OP_JALR;
            3: begin i.op = OP_LD; i.mr = 1; i.mtr = 1; end
            4: begin i.op = OP_ST; i.mw = 1; i.rw = 0; end
            default: i.op = OP_R;
        endcase
        return i;
    endfunction

    // Drive one edge's inputs, queue the expected result, advance past the edge.
    task automatic step(input in_t i, input bit stall, input bit flush);
        din = i;
        stall_mem = stall;
        flush_mem = flush;
        exp_cur = predict(exp_cur, i, stall, flush);
        sb.push_back(exp_cur);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        out_t got;
        got = sample();
        checks++;
        if (got !== RST) begin
            errors++;
            $display("FAIL reset_initial got=%h exp=%h", got, RST);
        end
        exp_cur = RST;
    endtask

    task automatic test_store();
        in_t i;
        out_t got, e;
        i = mk();
        i.op = OP_ST; i.mw = 1; i.rw = 0; i.st = 2'd0;
        i.rs2 = 32'h1122_3344; i.res = 32'h0000_1002;
        step(i, 0, 0);
        got = sample(); e = sb.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL store_sb got=%h exp=%h", got, e); end
        checks++;
        if (mem_wdata !== 32'h4444_4444 || mem_wstrb !== 4'b0100 || mem_mem_write !== 1'b1) begin
            errors++;
            $display("FAIL store_sb_fields wdata=%h wstrb=%b mw=%b exp 44444444/0100/1",
                     mem_wdata, mem_wstrb, mem_mem_write);
        end
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 4; k++) begin
                i.st = 2'(s);
                i.res = 32'h0000_2000 | 32'(k);
                i.rs2 = $urandom;
                step(i, 0, 0);
                got = sample(); e = sb.pop_front(); checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL store_sweep st=%0d a=%0d got=%h exp=%h", s, k, got, e);
                end
            end
        end
    endtask

    task automatic test_misaligned();
        in_t i;
        out_t got, e;
        i = mk();
        i.op = OP_ST; i.mw = 1; i.rw = 0; i.st = 2'd2; i.res = 32'h0000_1001;
        step(i, 0, 0);
        got = sample(); e = sb.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL mis_sw got=%h exp=%h", got, e); end
        checks++;
        if (mem_misaligned !== 1'b1 || mem_mem_write !== 1'b0 || mem_wstrb !== 4'b0000 ||
            mem_valid !== 1'b1) begin
            errors++;
            $display("FAIL mis_sw_fields mis=%b mw=%b wstrb=%b valid=%b exp 1/0/0000/1",
                     mem_misaligned, mem_mem_write, mem_wstrb, mem_valid);
        end
        i = mk();
        i.op = OP_LD; i.mr = 1; i.mtr = 1; i.lt = 3'd1; i.res = 32'h0000_1002;
        step(i, 0, 0);
        got = sample(); e = sb.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL ld_lh got=%h exp=%h", got, e); end
        checks++;
        if (mem_misaligned !== 1'b0 || mem_mem_read !== 1'b1) begin
            errors++;
            $display("FAIL ld_lh_fields mis=%b mr=%b exp 0/1", mem_misaligned, mem_mem_read);
        end
        for (int k = 0; k < 6; k++) begin
            i.lt = (k < 2) ? 3'd2 : (k < 4) ? 3'd4 : 3'd0;
            i.res = 32'h0000_3000 | 32'(k % 4 + 1);
            step(i, 0, 0);
            got = sample(); e = sb.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL ld_sweep k=%0d got=%h exp=%h", k, got, e); end
        end
    endtask

    task automatic test_branch();
        in_t i;
        out_t got, e;
        i = mk();
        i.op = OP_B; i.rw = 0; i.f3 = 3'b100; i.n = 1; i.v = 0;
        step(i, 0, 0);
        got = sample(); e = sb.pop_front(); checks++;
        if (got !== e || mem_branch_taken !== 1'b1) begin
            errors++; $display("FAIL br_blt got=%h exp=%h", got, e);
        end
        i = mk();
        i.op = OP_B; i.rw = 0; i.f3 = 3'b111; i.c = 0;
        step(i, 0, 0);
        got = sample(); e = sb.pop_front(); checks++;
        if (got !== e || mem_branch_taken !== 1'b0) begin
            errors++; $display("FAIL br_bgeu got=%h exp=%h", got, e);
        end
        i = mk();
        i.op = OP_B; i.rw = 0; i.f3 = 3'b000; i.z = 1; i.valid = 0;
        step(i, 0, 0);
        got = sample(); e = sb.pop_front(); checks++;
        if (got !== e || mem_branch_taken !== 1'b0 || mem_valid !== 1'b0) begin
            errors++; $display("FAIL br_beq_invalid got=%h exp=%h", got, e);
        end
        for (int f = 0; f < 8; f++) begin
            for (int fl = 0; fl < 16; fl += 3) begin
                i = mk();
                i.op = OP_B; i.rw = 0; i.f3 = 3'(f);
                {i.c, i.z, i.n, i.v} = 4'(fl);
                step(i, 0, 0);
                got = sample(); e = sb.pop_front(); checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL br_sweep f3=%0d flags=%0d got=%h exp=%h", f, fl, got, e);
                end
            end
        end
    endtask

    task automatic test_stall();
        in_t i;
        out_t got, e;
        i = mk();
        i.op = OP_ST; i.mw = 1; i.rw = 0; i.st = 2'd1; i.res = 32'h0000_4002; i.rs2 = 32'hAABB_CCDD;
        step(i, 0, 0);
        got = sample(); e = sb.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL stall_load got=%h exp=%h", got, e); end
        for (int k = 0; k < 3; k++) begin
            step(rand_in(), 1, 0);
            got = sample(); e = sb.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL stall_hold k=%0d got=%h exp=%h", k, got, e); end
        end
        step(rand_in(), 1, 1);
        got = sample(); e = sb.pop_front(); checks++;
        if (got !== e || mem_valid !== 1'b0 || mem_wstrb !== 4'b0000) begin
            errors++; $display("FAIL stall_flush got=%h exp=%h", got, e);
        end
        i = mk();
        i.res = 32'h0000_5555; i.rd = 5'd17;
        step(i, 0, 0);
        got = sample(); e = sb.pop_front(); checks++;
        if (got !== e || mem_addr !== 32'h0000_5555 || mem_rd !== 5'd17) begin
            errors++; $display("FAIL stall_release got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_jal();
        in_t i;
        out_t got, e;
        i = mk();
        i.op = OP_JAL; i.pc4 = 32'h0000_0204; i.res = 32'h0000_0300; i.rd = 5'd1;
        step(i, 0, 0);
        got = sample(); e = sb.pop_front(); checks++;
        if (got !== e || mem_alu_out !== 32'h0000_0204 || mem_addr !== 32'h0000_0300) begin
            errors++;
            $display("FAIL jal alu_out=%h addr=%h exp 00000204/00000300", mem_alu_out, mem_addr);
        end
    endtask

    task automatic test_reset_midrun();
        in_t i;
        out_t got, e;
        i = mk();
        i.op = OP_ST; i.mw = 1; i.rw = 0; i.st = 2'd2; i.res = 32'h0000_6000;
        step(i, 0, 0);
        got = sample(); e = sb.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL pre_reset got=%h exp=%h", got, e); end
        #3;
        rst_n = 1'b0;
        #1;
        got = sample(); checks++;
        if (got !== RST) begin errors++; $display("FAIL reset_async got=%h exp=%h", got, RST); end
        exp_cur = RST;
        @(posedge clk);
        #1;
        got = sample(); checks++;
        if (got !== RST) begin errors++; $display("FAIL reset_held got=%h exp=%h", got, RST); end
        rst_n = 1'b1;
        step(i, 0, 0);
        got = sample(); e = sb.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL post_reset got=%h exp=%h", got, e); end
    endtask

    task automatic test_back_to_back();
        out_t got, e;
        bit st, fl;
        for (int k = 0; k < 60; k++) begin
            st = ($urandom_range(0, 5) == 0);
            fl = ($urandom_range(0, 9) == 0);
            step(rand_in(), st, fl);
            got = sample(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL b2b k=%0d got=%h exp=%h", k, got, e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        stall_mem = 1'b0;
        flush_mem = 1'b0;
        din = '0;
        exp_cur = RST;
        #12;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_store();
        test_misaligned();
        test_branch();
        test_stall();
        test_jal();
        test_reset_midrun();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
